approx_ctrl: RTL and testbench

APPROX_CTRL -- requirements
Module: approx_ctrl

---
 rtl/approx_pkg.sv | 45 ++++
 rtl/sat_shift.sv | 32 +++
 rtl/approx_ctrl.sv | 148 ++++++++++++++
 tb/tb_approx_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// ============================================================================
//  Module   : approx_pkg
//  Brief    : Shared ALU opcodes, FSM encoding, Q2.14 constants and Horner
//             coefficients for the ln(x) approximation controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package approx_pkg;

    localparam logic [2:0] c_MODE_ADD_ONE  = 3'd0;
    localparam logic [2:0] c_MODE_SUB_ONE  = 3'd1;
    localparam logic [2:0] c_MODE_ADD_SUB  = 3'd2;
    localparam logic [2:0] c_MODE_MULTIPLY = 3'd3;
    localparam logic [2:0] c_MODE_IDLE     = 3'd4;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PREP = 3'd1;
    localparam logic [2:0] c_ST_MUL  = 3'd2;
    localparam logic [2:0] c_ST_ACC  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic signed [15:0] c_ONE = 16'sd16384;

    typedef struct packed {
        logic        neg;
        logic [15:0] mag;
    } coef_t;

    // Indexed by k: c0, c1, c2, c3, c4.
    localparam coef_t c_COEF_TBL [5] = '{
        '{1'b0, 16'd0},
        '{1'b0, 16'd16384},
        '{1'b1, 16'd8192},
        '{1'b0, 16'd5461},
        '{1'b1, 16'd4096}
    };

    function automatic logic [15:0] coef_value(input coef_t c);
        return c.neg ? (~c.mag + 16'd1) : c.mag;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_shift.sv
// ============================================================================
//  Module   : sat_shift
//  Brief    : Arithmetic right shift of a 32-bit signed value followed by
//             saturation to the signed 16-bit range.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_shift (
    input  logic [31:0] i_din,
    input  logic [4:0]  i_shift,
    output logic [15:0] o_dout
);

    logic signed [31:0] w_shifted;

    // Arithmetic shift floors toward minus infinity before clamping.
    assign w_shifted = $signed(i_din) >>> i_shift;

    always_comb begin
        if (w_shifted > 32'sd32767) begin
            o_dout = 16'h7fff;
        end else if (w_shifted < -32'sd32768) begin
            o_dout = 16'h8000;
        end else begin
            o_dout = w_shifted[15:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/approx_ctrl.sv
// ============================================================================
//  Module   : approx_ctrl
//  Brief    : Sequences an external ALU through the Horner evaluation of
//             ln(1+t), t = x - 1.0, in signed Q2.14 with saturation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module approx_ctrl
    import approx_pkg::*;
#(
    parameter int FRAC_BITS = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] x_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] y_o,
    output logic [2:0]  alu_mode_o,
    output logic [15:0] alu_op_a_o,
    output logic [15:0] alu_op_b_o,
    output logic        alu_sigma_n_o,
    input  logic [31:0] alu_res_i
);

    localparam logic [4:0] c_FRAC_SHIFT = 5'(FRAC_BITS);

    logic [2:0]  r_state;
    logic [15:0] r_x;
    logic [15:0] r_t;
    logic [15:0] r_y;
    logic [1:0]  r_k;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_y_out;

    logic [15:0] w_mul_sat;
    logic [15:0] w_res_sat;
    coef_t       w_coef;
    logic [2:0]  w_alu_mode;
    logic [15:0] w_op_a;
    logic [15:0] w_op_b;
    logic        w_sigma;

    sat_shift u_sat_mul (
        .i_din   (alu_res_i),
        .i_shift (c_FRAC_SHIFT),
        .o_dout  (w_mul_sat)
    );

    sat_shift u_sat_res (
        .i_din   (alu_res_i),
        .i_shift (5'd0),
        .o_dout  (w_res_sat)
    );

    assign w_coef = c_COEF_TBL[{1'b0, r_k}];

    // ALU drive is a pure decode of registered state, so the ALU result never
    // feeds back into its own operands within a cycle.
    always_comb begin
        w_alu_mode = c_MODE_IDLE;
        w_op_a     = '0;
        w_op_b     = '0;
        w_sigma    = 1'b0;
        case (r_state)
            c_ST_PREP: begin
                w_alu_mode = c_MODE_SUB_ONE;
                w_op_a     = r_x;
            end
            c_ST_MUL: begin
                w_alu_mode = c_MODE_MULTIPLY;
                w_op_a     = r_y;
                w_op_b     = r_t;
            end
            c_ST_ACC: begin
                w_alu_mode = c_MODE_ADD_SUB;
                w_op_a     = r_y;
                w_op_b     = w_coef.mag;
                w_sigma    = w_coef.neg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_x     <= '0;
            r_t     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y_out <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_x     <= x_i;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_PREP;
                    end
                end
                c_ST_PREP: begin
                    r_t     <= w_res_sat;
                    r_y     <= coef_value(c_COEF_TBL[4]);
                    r_k     <= 2'd3;
                    r_state <= c_ST_MUL;
                end
                c_ST_MUL: begin
                    r_y     <= w_mul_sat;
                    r_state <= c_ST_ACC;
                end
                c_ST_ACC: begin
                    r_y <= w_res_sat;
                    if (r_k == 2'd0) begin
                        r_y_out <= w_res_sat;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_k     <= r_k - 2'd1;
                        r_state <= c_ST_MUL;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign y_o           = r_y_out;
    assign alu_mode_o    = w_alu_mode;
    assign alu_op_a_o    = w_op_a;
    assign alu_op_b_o    = w_op_b;
    assign alu_sigma_n_o = w_sigma;

endmodule

`default_nettype wire

// File: tb/tb_approx_ctrl.sv
// ============================================================================
//  Module   : tb_approx_ctrl
//  Brief    : Self-checking bench for approx_ctrl with a behavioural ALU and
//             a per-cycle reference model of the Horner evaluation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_approx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] x_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] y_o;
    logic [2:0]  alu_mode_o;
    logic [15:0] alu_op_a_o;
    logic [15:0] alu_op_b_o;
    logic        alu_sigma_n_o;
    logic [31:0] alu_res_i;

    approx_ctrl #(.FRAC_BITS(14)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .x_i           (x_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .y_o           (y_o),
        .alu_mode_o    (alu_mode_o),
        .alu_op_a_o    (alu_op_a_o),
        .alu_op_b_o    (alu_op_b_o),
        .alu_sigma_n_o (alu_sigma_n_o),
        .alu_res_i     (alu_res_i)
    );

    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        longint a, b, r;
        a = longint'($signed(alu_op_a_o));
        b = longint'($signed(alu_op_b_o));
        case (alu_mode_o)
            3'd0:    r = a + 16384;
            3'd1:    r = a - 16384;
            3'd2:    r = alu_sigma_n_o ? a - b : a + b;
            3'd3:    r = a * b;
            default: r = 0;
        endcase
        alu_res_i = r[31:0];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ln(1+t) via Horner with saturation after every step.
    int coef [4] = '{0, 16384, -8192, 5461};
    int m_t;
    int m_mul [4];
    int m_acc [4];

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic void model_eval(input int x);
        int y;
        m_t = sat16(longint'(x) - 16384);
        y   = -4096;
        for (int i = 0; i < 4; i++) begin
            y        = sat16((longint'(y) * longint'(m_t)) >>> 14);
            m_mul[i] = y;
            y        = sat16(longint'(y) + longint'(coef[3-i]));
            m_acc[i] = y;
        end
    endfunction

    // Per-cycle compare process; phase counts cycles since acceptance.
    int phase = 0;
    int cx    = 0;
    int yhold = 0;

    always @(posedge clk) begin
        int e_mode, e_a, e_b, e_s, e_busy, e_done, i, c;
        if (rst) begin
            phase = 0;
            yhold = 0;
        end else if (phase == 0) begin
            if (start_i) begin
                cx = int'($signed(x_i));
                model_eval(cx);
                phase = 1;
            end
        end else if (phase == 10) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == 10) yhold = m_acc[3];
        end
        #1;
        e_mode = 4; e_a = 0; e_b = 0; e_s = 0; e_busy = 0; e_done = 0;
        if (phase == 1) begin
            e_mode = 1; e_a = cx; e_busy = 1;
        end else if (phase == 10) begin
            e_busy = 1; e_done = 1;
        end else if (phase >= 2 && phase % 2 == 0) begin
            i = (phase - 2) / 2;
            e_mode = 3; e_busy = 1; e_b = m_t;
            e_a = (i == 0) ? -4096 : m_acc[i-1];
        end else if (phase >= 3) begin
            i = (phase - 3) / 2;
            c = coef[3-i];
            e_mode = 2; e_busy = 1; e_a = m_mul[i];
            e_b = (c < 0) ? -c : c;
            e_s = (c < 0) ? 1 : 0;
        end
        check("alu_mode", alu_mode_o, e_mode);
        check("alu_op_a", $signed(alu_op_a_o), e_a);
        check("alu_op_b", $signed(alu_op_b_o), e_b);
        check("alu_sigma", alu_sigma_n_o, e_s);
        check("busy", busy_o, e_busy);
        check("done", done_o, e_done);
        check("y_o", $signed(y_o), yhold);
    end

    task automatic run_one(input int x, output int lat, output int y);
        @(negedge clk);
        start_i = 1'b1;
        x_i     = 16'(x);
        @(negedge clk);
        start_i = 1'b0;
        x_i     = 16'($urandom);
        lat     = -1;
        y       = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done_o) begin
                lat = n;
                y   = int'($signed(y_o));
                break;
            end
            @(negedge clk);
            x_i = 16'($urandom);
        end
    endtask

    initial begin
        int lat, y, nd, d1, d2;
        int exp_mul [4] = '{-2048, 1706, -3243, 6570};
        int exp_acc [4] = '{3413, -6486, 13141, 6570};
        rst     = 1'b1;
        start_i = 1'b0;
        x_i     = '0;

        // Hand-computed pins on the model itself
        model_eval(24576);
        check("model_t_1p5", m_t, 8192);
        for (int i = 0; i < 4; i++) begin
            check("model_mul_1p5", m_mul[i], exp_mul[i]);
            check("model_acc_1p5", m_acc[i], exp_acc[i]);
        end
        model_eval(-32768);
        check("model_t_min", m_t, -32768);
        check("model_y_min", m_acc[3], -32768);
        model_eval(16384);
        check("model_y_one", m_acc[3], 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_one(16384, lat, y);
        check("lat_x1p0", lat, 10);
        check("y_x1p0", y, 0);
        run_one(24576, lat, y);
        check("lat_x1p5", lat, 10);
        check("y_x1p5", y, 6570);
        run_one(-32768, lat, y);
        check("lat_xmin", lat, 10);
        check("y_xmin", y, -32768);

        // start held high for 20 cycles
        @(negedge clk);
        start_i = 1'b1;
        x_i     = 16'd24576;
        nd = 0; d1 = -1; d2 = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 20) start_i = 1'b0;
            if (done_o) begin
                nd++;
                if (nd == 1) d1 = i;
                if (nd == 2) d2 = i;
            end
        end
        check("hold_done_count", nd, 2);
        check("hold_done_first", d1, 10);
        check("hold_done_second", d2, 21);

        // Reset at cycle 5 of an evaluation
        @(negedge clk);
        start_i = 1'b1;
        x_i     = 16'd24576;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_y_o", y_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_mode", alu_mode_o, 4);
        check("rst_op_a", alu_op_a_o, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        check("rst_no_done", nd, 0);
        run_one(24576, lat, y);
        check("lat_after_rst", lat, 10);
        check("y_after_rst", y, 6570);

        // Random traffic: starts during busy, changing x, occasional reset
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start_i = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 7))
                0:       x_i = 16'd16384;
                1:       x_i = 16'h8000;
                2:       x_i = 16'h7fff;
                3:       x_i = 16'h0000;
                default: x_i = 16'($urandom);
            endcase
        end
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
